countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter: WIDTH, default 8, counter and load-value width in bits.
REQ-002 Port: clk  input  1  sole clock; all state updates on posedge.
REQ-003 Port: rstn  input  1  asynchronous, active-low reset.
REQ-004 Port: load_valid  input  1  request to load a new count.
REQ-005 Port: load_ready  output  1  block can accept a load; high only in IDLE.
REQ-006 Port: load_val  input  WIDTH  start value, sampled when the load handshake completes.
REQ-007 Port: hold  input  1  freezes counting while high in RUN.
REQ-008 Port: abort  input  1  cancels a running count.
REQ-009 Port: cnt  output  WIDTH  current registered count.
REQ-010 Port: busy  output  1  high while in RUN.
REQ-011 Port: done  output  1  single-cycle terminal-count pulse, registered.

Function
REQ-012 States are IDLE and RUN only; load_ready = (state==IDLE); busy = (state==RUN).
REQ-013 A load handshake completes at a posedge where load_valid and load_ready are both high.
REQ-014 At that edge: cnt <= load_val; if load_val != 0, go to RUN; if load_val == 0, stay in IDLE and set done=1 for one cycle.
REQ-015 In RUN, with hold=0 and abort=0, cnt <= cnt - 1 each edge; modulo-2^WIDTH arithmetic, no other width growth.
REQ-016 At the edge where cnt goes from 1 to 0: done <= 1 for exactly one cycle and state <= IDLE (default build).
REQ-017 Load value N yields done high in the cycle following the Nth edge after acceptance; cnt reads 0 in that cycle.
REQ-018 In RUN with hold=1: cnt, state and done are unchanged (done=0).
REQ-019 abort=1 in RUN: state <= IDLE and cnt <= 0, with no done pulse; abort wins over hold and over the terminal-count edge.
REQ-020 abort in IDLE has no effect; hold in IDLE has no effect.
REQ-021 load_valid while busy is ignored and not queued.
REQ-022 done is 0 in every cycle not named in REQ-014/REQ-016/REQ-027.
REQ-023 cnt never wraps below 0 in the default build; 0 in RUN is unreachable.

Reset
REQ-024 rstn low forces state=IDLE, cnt=0, done=0 and busy=0 immediately, regardless of clk.
REQ-025 Reset mid-count discards the count; no done is produced; load_ready is high once rstn deasserts.
REQ-026 The reload register from REQ-027 resets to 0.

Configuration
REQ-027 Macro COUNTDOWN_AUTO_RELOAD_EN, when defined, adds a WIDTH-bit reload register captured on every load handshake.
- At the terminal edge (cnt 1->0) with a nonzero reload value: done pulses, state stays RUN, and the next unheld edge sets cnt <= reload, giving period N+1 cycles.
- abort still returns to IDLE and clears cnt.
REQ-028 Without COUNTDOWN_AUTO_RELOAD_EN: no reload register exists and REQ-016 applies unconditionally.

Structure
REQ-029 Shared package countdown_pkg holds the state enum (IDLE, RUN) and the default WIDTH constant.
REQ-030 The block is a single flat module; no sub-module is required.

Verification
REQ-031 Load 5, hold=0 -> cnt reads 5,4,3,2,1,0 on successive cycles; done=1 only in the cnt=0 cycle; load_ready returns to 1 that same cycle.
REQ-032 Load 0 -> done=1 the next cycle, busy never asserts, cnt=0.
REQ-033 Load 4, hold=1 for 3 cycles after the first decrement -> cnt holds at 3 for 3 cycles; done arrives 3 cycles late.
REQ-034 Load 3, assert abort on the same edge cnt would go 1->0 -> IDLE, cnt=0, done never asserts; a second load_valid during RUN is ignored.
REQ-035 rstn pulsed low mid-count from 200 (WIDTH=8) -> outputs zero asynchronously, no done; a load of 255 then counts down fully.
REQ-036 With COUNTDOWN_AUTO_RELOAD_EN, load 2 -> done pulses every 3 cycles until abort, after which the block is idle with cnt=0.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown timer.
package countdown_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with hold/abort and a registered terminal-count pulse.
// Optional feature: define COUNTDOWN_AUTO_RELOAD_EN to restart from the last loaded value.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_val,
    input  logic             hold,
    input  logic             abort,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_reg;
    logic [WIDTH-1:0] cnt_reg;
    logic             done_reg;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_reg;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            done_reg   <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_reg <= '0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // load_ready is high throughout IDLE, so load_valid alone completes the handshake
                    if (load_valid) begin
                        cnt_reg <= load_val;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        reload_reg <= load_val;
`endif
                        if (load_val == '0) begin
                            done_reg <= 1'b1;
                        end else begin
                            state_reg <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end else if (!hold) begin
                        if (cnt_reg == ONE) begin
                            cnt_reg  <= '0;
                            done_reg <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            if (reload_reg == '0) begin
                                state_reg <= IDLE;
                            end
`else
                            state_reg <= IDLE;
`endif
                        end
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        // zero in RUN only occurs for one cycle after a terminal edge
                        else if (cnt_reg == '0) begin
                            cnt_reg <= reload_reg;
                        end
`endif
                        else begin
                            cnt_reg <= cnt_reg - ONE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign load_ready = (state_reg == IDLE);
    assign busy       = (state_reg == RUN);
    assign cnt        = cnt_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: stimulus queues expected outputs, a negedge monitor checks them.
module tb_countdown_timer;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    localparam logic RELOAD = 1'b1;
`else
    localparam logic RELOAD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_val;
    logic       hold;
    logic       abort;
    logic [7:0] cnt;
    logic       busy;
    logic       done;

    typedef struct {
        string      name;
        logic [7:0] cnt;
        logic       done;
        logic       busy;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    countdown_timer #(.WIDTH(8)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_val   (load_val),
        .hold       (hold),
        .abort      (abort),
        .cnt        (cnt),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic compare(input exp_t e);
        vectors++;
        if (cnt !== e.cnt || done !== e.done || busy !== e.busy || load_ready !== !e.busy) begin
            miscompares++;
            $display("FAIL %s: got cnt=%0d done=%b busy=%b rdy=%b, expected cnt=%0d done=%b busy=%b rdy=%b",
                     e.name, cnt, done, busy, load_ready, e.cnt, e.done, e.busy, !e.busy);
        end else begin
            $display("ok   %s: cnt=%0d done=%b busy=%b rdy=%b", e.name, cnt, done, busy, load_ready);
        end
    endtask

    // Monitor: one expected entry per clock, checked mid-cycle
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            compare(sb_q.pop_front());
        end
    end

    task automatic cyc(input string name, input logic lv, input logic [7:0] val, input logic h,
                       input logic ab, input logic [7:0] e_cnt, input logic e_done, input logic e_busy);
        exp_t e;
        load_valid = lv;
        load_val   = val;
        hold       = h;
        abort      = ab;
        @(posedge clk);
        #1;
        e.name = name;
        e.cnt  = e_cnt;
        e.done = e_done;
        e.busy = e_busy;
        sb_q.push_back(e);
    endtask

    task automatic check_now(input string name, input logic [7:0] e_cnt, input logic e_done,
                             input logic e_busy);
        exp_t e;
        e.name = name;
        e.cnt  = e_cnt;
        e.done = e_done;
        e.busy = e_busy;
        compare(e);
    endtask

    task automatic drain();
        int waited = 0;
        while (sb_q.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        #2;
        if (sb_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d pending entries, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        rstn       = 1'b0;
        load_valid = 1'b0;
        load_val   = '0;
        hold       = 1'b0;
        abort      = 1'b0;
        #12;
        check_now("reset_state", 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;

        // load 5, free run to terminal count
        cyc("ld5_accept", 1, 8'd5, 0, 0, 8'd5, 0, 1);
        cyc("ld5_c4",     0, 8'd0, 0, 0, 8'd4, 0, 1);
        cyc("ld5_c3",     0, 8'd0, 0, 0, 8'd3, 0, 1);
        cyc("ld5_c2",     0, 8'd0, 0, 0, 8'd2, 0, 1);
        cyc("ld5_c1",     0, 8'd0, 0, 0, 8'd1, 0, 1);
        cyc("ld5_done",   0, 8'd0, 0, 0, 8'd0, 1, RELOAD);
        cyc("ld5_abort",  0, 8'd0, 0, 1, 8'd0, 0, 0);
        cyc("idle_quiet", 0, 8'd0, 0, 0, 8'd0, 0, 0);

        // load 0: immediate done, never busy
        cyc("ld0_done",   1, 8'd0, 0, 0, 8'd0, 1, 0);
        cyc("ld0_after",  0, 8'd0, 0, 0, 8'd0, 0, 0);

        // hold/abort in IDLE do nothing
        cyc("idle_abort", 0, 8'd0, 0, 1, 8'd0, 0, 0);
        cyc("idle_hold",  0, 8'd0, 1, 0, 8'd0, 0, 0);

        // load 4 with a 3-cycle hold after the first decrement
        cyc("ld4_accept", 1, 8'd4, 0, 0, 8'd4, 0, 1);
        cyc("ld4_c3",     0, 8'd0, 0, 0, 8'd3, 0, 1);
        cyc("ld4_hold1",  0, 8'd0, 1, 0, 8'd3, 0, 1);
        cyc("ld4_hold2",  0, 8'd0, 1, 0, 8'd3, 0, 1);
        cyc("ld4_hold3",  0, 8'd0, 1, 0, 8'd3, 0, 1);
        cyc("ld4_c2",     0, 8'd0, 0, 0, 8'd2, 0, 1);
        cyc("ld4_c1",     0, 8'd0, 0, 0, 8'd1, 0, 1);
        cyc("ld4_done",   0, 8'd0, 0, 0, 8'd0, 1, RELOAD);
        cyc("ld4_abort",  0, 8'd0, 0, 1, 8'd0, 0, 0);

        // load 3, ignored reload attempt, abort (with hold) on the terminal edge
        cyc("ld3_accept", 1, 8'd3, 0, 0, 8'd3, 0, 1);
        cyc("ld3_ignld",  1, 8'd9, 0, 0, 8'd2, 0, 1);
        cyc("ld3_c1",     0, 8'd0, 0, 0, 8'd1, 0, 1);
        cyc("ld3_abort",  0, 8'd0, 1, 1, 8'd0, 0, 0);
        cyc("ld3_idle",   0, 8'd0, 0, 0, 8'd0, 0, 0);

        // load 200, asynchronous reset mid-count
        cyc("ld200_acc",  1, 8'd200, 0, 0, 8'd200, 0, 1);
        cyc("ld200_199",  0, 8'd0,   0, 0, 8'd199, 0, 1);
        cyc("ld200_198",  0, 8'd0,   0, 0, 8'd198, 0, 1);
        drain();
        rstn = 1'b0;
        #1;
        check_now("async_rst", 8'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_now("rst_held", 8'd0, 1'b0, 1'b0);
        rstn = 1'b1;

        // full-range count from 255
        cyc("ld255_acc", 1, 8'd255, 0, 0, 8'd255, 0, 1);
        for (int v = 254; v >= 1; v--) begin
            cyc("ld255_dec", 0, 8'd0, 0, 0, 8'(v), 0, 1);
        end
        cyc("ld255_done",  0, 8'd0, 0, 0, 8'd0, 1, RELOAD);
        cyc("ld255_abort", 0, 8'd0, 0, 1, 8'd0, 0, 0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        // auto-reload: load 2 gives a done every 3 cycles
        cyc("ar_accept", 1, 8'd2, 0, 0, 8'd2, 0, 1);
        for (int p = 0; p < 3; p++) begin
            cyc("ar_c1",     0, 8'd0, 0, 0, 8'd1, 0, 1);
            cyc("ar_done",   0, 8'd0, 0, 0, 8'd0, 1, 1);
            cyc("ar_reload", 0, 8'd0, 0, 0, 8'd2, 0, 1);
        end
        cyc("ar_abort", 0, 8'd0, 0, 1, 8'd0, 0, 0);
        cyc("ar_idle",  0, 8'd0, 0, 0, 8'd0, 0, 0);
`endif

        load_valid = 1'b0;
        hold       = 1'b0;
        abort      = 1'b0;
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
